ssram_arbiter: RTL and testbench
================================

SSRAM_ARBITER -- requirements
Module: ssram_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of registers in the bank (max 256).
REQ-003 The block SHALL have port clk  input  1  the single clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports a_req, b_req  input  1 each  access request from requester A or B.
REQ-006 The block SHALL have ports a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-007 The block SHALL have ports a_addr, b_addr  input  8 each  register index.
REQ-008 The block SHALL have ports a_wdata, b_wdata  input  WIDTH each  write data.
REQ-009 The block SHALL have ports a_ack, b_ack  output  1 each  one-cycle completion pulse.
REQ-010 The block SHALL have port rdata  output  WIDTH  read data, valid while an ack is high.
REQ-011 The block SHALL have ports row, column  output  16 each  one-hot bank select.
REQ-012 The block SHALL have ports we, re  output  1 each  bank write and read strobes.
REQ-013 The block SHALL have port bus_wdata  output  WIDTH  data driven onto the bank bus.
REQ-014 The block SHALL have port bus_oe  output  1  bus drive enable.
REQ-015 The block SHALL have port bus_rdata  input  WIDTH  bank bus read value.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, STROBE and RELEASE, and SHALL advance one state per clock in the order IDLE->SETUP->STROBE->RELEASE->IDLE.
REQ-017 In IDLE with any req high, the arbiter SHALL latch the winner's we, addr and wdata and a grant-owner flag, then go to SETUP.
REQ-018 With no req high, IDLE SHALL persist.
REQ-019 When only one req is high, that requester SHALL win.
REQ-020 When both reqs are high, the requester not granted last SHALL win (round-robin pointer, updated on every grant).
REQ-021 In SETUP and STROBE, row SHALL equal one-hot(addr[7:4]) and column SHALL equal one-hot(addr[3:0]).
REQ-022 In IDLE and RELEASE, row and column SHALL be 0.
REQ-023 we SHALL be high in SETUP and STROBE for a write, and re SHALL be high in SETUP and STROBE for a read.
REQ-024 For a write, bus_oe SHALL be high and bus_wdata SHALL equal the latched wdata in SETUP and STROBE; in all other cases bus_oe SHALL be 0.
REQ-025 For a read, bus_rdata SHALL be captured into rdata at the end of STROBE.
REQ-026 rdata SHALL hold its value until the next read capture.
REQ-027 The owner's ack SHALL pulse high for exactly the RELEASE cycle, 3 cycles after the request is sampled in IDLE; the other ack SHALL stay 0.
REQ-028 A requester SHALL hold req, we, addr and wdata stable until its ack; the block SHALL ignore changes after latching.
REQ-029 A requester SHALL drop req in the ack cycle; a req still high in the cycle after RELEASE SHALL be treated as a new request.
REQ-030 For addr >= DEPTH, row, column, we and re SHALL stay 0 and bus_oe SHALL stay 0, the ack SHALL still pulse at the same latency, and a read SHALL return rdata = 0.
REQ-031 Throughput SHALL be one access per 4 cycles; RELEASE guarantees at least one deselected cycle between accesses, including back-to-back accesses to the same register.

Reset
REQ-032 While rst is high at a clock edge, the FSM SHALL enter IDLE.
REQ-033 While rst is high at a clock edge, row, column, we, re, bus_oe, a_ack and b_ack SHALL be 0 and rdata SHALL be 0.
REQ-034 While rst is high at a clock edge, the round-robin pointer SHALL be set so that A wins the first tie.
REQ-035 Reset in any state SHALL abort the access with no ack issued.

Verification
REQ-036 Single write: A writes addr 0x25, data 0x1234 -> SETUP/STROBE show row = 0x0004, column = 0x0020, we = 1, bus_oe = 1; a_ack 3 cycles after the request is sampled.
REQ-037 Read-back: A reads 0x25 with bus_rdata = 0x1234 -> rdata = 0x1234 while a_ack is high, and re = 1 for 2 cycles.
REQ-038 Tie after reset: A and B both request continuously -> grants alternate A, B, A, B, with acks 4 cycles apart and never both high.
REQ-039 Out of range with DEPTH = 200: read addr 0xF0 -> row = 0, column = 0, re = 0; ack after 3 cycles with rdata = 0.
REQ-040 Reset in STROBE of a B write -> the next cycle shows IDLE, all strobes 0 and no b_ack; B re-requests and completes normally.
REQ-041 Back-to-back writes to the same address -> a cycle with row = 0 and column = 0 separates the two strobe windows.

Source files
------------

// File: rtl/ssram_arbiter.sv
// Two-port round-robin arbiter in front of a row/column-selected register bank.
// Each access walks IDLE->SETUP->STROBE->RELEASE, so one access completes every 4 cycles.
module ssram_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  // Requester handshake: req is held with we/addr/wdata stable until the
  // matching ack pulses for one cycle (RELEASE); the requester drops req in
  // that ack cycle. A req still high in the following IDLE is a new request.
  input  logic             a_req,
  input  logic             b_req,
  input  logic             a_we,
  input  logic             b_we,
  input  logic [7:0]       a_addr,
  input  logic [7:0]       b_addr,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             a_ack,
  output logic             b_ack,
  output logic [WIDTH-1:0] rdata,
  output logic [15:0]      row,
  output logic [15:0]      column,
  output logic             we,
  output logic             re,
  output logic [WIDTH-1:0] bus_wdata,
  output logic             bus_oe,
  input  logic [WIDTH-1:0] bus_rdata,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  state_t           state_q, state_d;
  logic             last_b_q, last_b_d;
  logic             owner_b_q, owner_b_d;
  logic             we_q, we_d;
  logic [7:0]       addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             grant_b;
  logic             in_range;
  logic             active;

  assign in_range = ({1'b0, addr_q} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;  // B counts as last granted, so A wins the first tie
      owner_b_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      owner_b_q <= owner_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    owner_b_d = owner_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    grant_b   = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant_b   = b_req && (!a_req || !last_b_q);
          owner_b_d = grant_b;
          last_b_d  = grant_b;
          we_d      = grant_b ? b_we    : a_we;
          addr_d    = grant_b ? b_addr  : a_addr;
          wdata_d   = grant_b ? b_wdata : a_wdata;
          state_d   = SETUP;
        end
      end
      SETUP:   state_d = STROBE;
      STROBE: begin
        state_d = RELEASE;
        // Out-of-range reads never touch the bank and return zero.
        if (!we_q) rdata_d = in_range ? bus_rdata : '0;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign active = ((state_q == SETUP) || (state_q == STROBE)) && in_range;

  always_comb begin
    row       = '0;
    column    = '0;
    we        = 1'b0;
    re        = 1'b0;
    bus_oe    = 1'b0;
    bus_wdata = '0;
    if (active) begin
      row    = 16'h0001 << addr_q[7:4];
      column = 16'h0001 << addr_q[3:0];
      we     = we_q;
      re     = !we_q;
      bus_oe = we_q;
      if (we_q) bus_wdata = wdata_q;
    end
  end

  assign a_ack       = (state_q == RELEASE) && !owner_b_q;
  assign b_ack       = (state_q == RELEASE) && owner_b_q;
  assign rdata       = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ssram_arbiter.sv
// Directed bench for ssram_arbiter (DEPTH = 200): an ack monitor pops a
// scoreboard queue of expected {owner_b, is_read, rdata} completions.
module tb_ssram_arbiter;

  localparam int W = 16;
  localparam int DEPTH = 200;
  localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_STROBE = 2'd2, S_RELEASE = 2'd3;

  logic          clk, rst;
  logic          a_req, b_req, a_we, b_we;
  logic [7:0]    a_addr, b_addr;
  logic [W-1:0]  a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [W-1:0]  rdata;
  logic [15:0]   row, column;
  logic          we, re;
  logic [W-1:0]  bus_wdata;
  logic          bus_oe;
  logic [W-1:0]  bus_rdata;
  logic [1:0]    dbg_state;

  logic [W+1:0]  exp_q[$];
  logic [W-1:0]  last_rd;
  int            checks = 0;
  int            failures = 0;

  ssram_arbiter #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .rdata(rdata),
    .row(row), .column(column), .we(we), .re(re),
    .bus_wdata(bus_wdata), .bus_oe(bus_oe), .bus_rdata(bus_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // scoreboard: every ack must match the oldest expected completion
  always @(negedge clk) begin
    if (a_ack || b_ack) begin
      logic [W+1:0] e;
      chk("ack_exclusive", {31'd0, a_ack & b_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_owner_b", {31'd0, b_ack}, {31'd0, e[W+1]});
        if (e[W]) chk("ack_rdata", {16'd0, rdata}, {16'd0, e[W-1:0]});
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0; bus_rdata = 0;
    step(); step();
    chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("rst_rowcol", {row, column}, 32'd0);
    chk("rst_strobes", {28'd0, we, re, bus_oe, a_ack | b_ack}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    rst = 1'b0;
    last_rd = '0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE.
  task automatic access(input bit is_b, input bit wr, input logic [7:0] addr,
                        input logic [W-1:0] wd, input logic [W-1:0] rd);
    bit in_rng;
    logic [15:0] erow, ecol;
    in_rng = (int'(addr) < DEPTH);
    erow = in_rng ? (16'h0001 << addr[7:4]) : 16'h0;
    ecol = in_rng ? (16'h0001 << addr[3:0]) : 16'h0;
    bus_rdata = rd;
    if (is_b) begin b_req = 1; b_we = wr; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = wr; a_addr = addr; a_wdata = wd; end
    exp_q.push_back({is_b, !wr, (wr || !in_rng) ? 16'h0 : rd});
    for (int ph = 0; ph < 2; ph++) begin
      step();
      chk("win_state", {30'd0, dbg_state}, (ph == 0) ? 32'(S_SETUP) : 32'(S_STROBE));
      chk("win_row", {16'd0, row}, {16'd0, erow});
      chk("win_col", {16'd0, column}, {16'd0, ecol});
      chk("win_we_re_oe", {29'd0, we, re, bus_oe},
          {29'd0, in_rng & wr, in_rng & !wr, in_rng & wr});
      if (in_rng && wr) chk("win_bus_wdata", {16'd0, bus_wdata}, {16'd0, wd});
      chk("win_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
      // latched request must ignore later input changes
      if (is_b) begin b_addr = 8'($urandom_range(0, 255)); b_wdata = 16'($urandom); b_we = !wr; end
      else      begin a_addr = 8'($urandom_range(0, 255)); a_wdata = 16'($urandom); a_we = !wr; end
    end
    step();
    chk("rel_state", {30'd0, dbg_state}, 32'(S_RELEASE));
    chk("rel_ack", {30'd0, a_ack, b_ack}, is_b ? 32'd1 : 32'd2);
    chk("rel_deselect", {row, column}, 32'd0);
    chk("rel_strobes", {29'd0, we, re, bus_oe}, 32'd0);
    if (!wr) last_rd = in_rng ? rd : '0;
    a_req = 0; b_req = 0;
    step();
    chk("idle_state", {30'd0, dbg_state}, 32'(S_IDLE));
    chk("idle_deselect", {row, column}, 32'd0);
    chk("idle_rdata_hold", {16'd0, rdata}, {16'd0, last_rd});
  endtask

  initial begin
    step();
    apply_reset();
    step();
    chk("idle_persist", {30'd0, dbg_state}, 32'(S_IDLE));

    // single write with literal window values
    access(0, 1, 8'h25, 16'h1234, 16'h0);
    // read-back
    access(0, 0, 8'h25, 16'h0, 16'h1234);
    chk("readback_value", {16'd0, rdata}, 32'h1234);
    // back-to-back writes to the same register
    access(1, 1, 8'h25, 16'hAAAA, 16'h0);
    access(1, 1, 8'h25, 16'h5555, 16'h0);
    // out of range read returns zero and leaves the bank deselected
    access(0, 0, 8'hF0, 16'h0, 16'hBEEF);
    chk("oor_rdata", {16'd0, rdata}, 32'd0);
    // boundary addresses around DEPTH
    access(1, 0, 8'(DEPTH - 1), 16'h0, 16'h0C7C);
    access(0, 1, 8'(DEPTH), 16'h7777, 16'h0);

    // tie after reset: A, B, A, B with acks 4 cycles apart
    apply_reset();
    a_req = 1; a_we = 1; a_addr = 8'h11; a_wdata = 16'h0A0A;
    b_req = 1; b_we = 1; b_addr = 8'h22; b_wdata = 16'h0B0B;
    exp_q.push_back({1'b0, 1'b0, 16'h0});
    exp_q.push_back({1'b1, 1'b0, 16'h0});
    exp_q.push_back({1'b0, 1'b0, 16'h0});
    exp_q.push_back({1'b1, 1'b0, 16'h0});
    for (int i = 1; i < 16; i++) begin
      step();
      if (i % 4 == 3) chk("tie_ack", {30'd0, a_ack, b_ack}, ((i / 4) % 2 == 0) ? 32'd2 : 32'd1);
      else            chk("tie_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
    end
    a_req = 0; b_req = 0;
    step();
    chk("tie_done", {30'd0, dbg_state}, 32'(S_IDLE));

    // reset during STROBE of a B write aborts without an ack
    b_req = 1; b_we = 1; b_addr = 8'h37; b_wdata = 16'hA5A5;
    step();
    step();
    chk("abort_in_strobe", {30'd0, dbg_state}, 32'(S_STROBE));
    rst = 1; b_req = 0;
    step();
    chk("abort_state", {30'd0, dbg_state}, 32'(S_IDLE));
    chk("abort_strobes", {row[14:0], column, we, re, bus_oe, b_ack}, 32'd0);
    rst = 0; last_rd = '0;
    step();
    chk("abort_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
    access(1, 1, 8'h37, 16'hA5A5, 16'h0);

    // short random sequence
    for (int k = 0; k < 8; k++)
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 16'($urandom), 16'($urandom));

    step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
